ladybird_timer: RTL and testbench
=================================

LADYBIRD_TIMER -- requirements
Module: ladybird_timer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DIV_W SHALL default to 8 and set the prescaler width in bits.
REQ-003 Parameter XLEN SHALL default to 32 and set the bus data width.
REQ-004 Port clk: input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-006 Port req: input, 1 bit, bus access request.
REQ-007 Port we: input, 1 bit, write enable, qualified by req.
REQ-008 Port addr: input, 5 bits, byte address; addr[4:2] selects the register and addr[1:0] is ignored.
REQ-009 Port wdata: input, XLEN bits, write data.
REQ-010 Port be: input, 4 bits, byte enables for writes.
REQ-011 Port gnt: output, 1 bit, request accepted.
REQ-012 Port rvalid: output, 1 bit, read data valid.
REQ-013 Port rdata: output, XLEN bits, read data.
REQ-014 Port pending: output, 1 bit, timer interrupt pending level, consumed by the core.
REQ-015 Port complete: input, 1 bit, one-cycle interrupt-complete pulse from the core.

Function
REQ-016 Register map by addr[4:2]:
- 0 MTIME_LO
- 1 MTIME_HI
- 2 MTIMECMP_LO
- 3 MTIMECMP_HI
- 4 CTRL: bit0 EN, bit1 IE, other bits read 0
- 5 PRESCALE: DIV_W bits, zero-extended on read
- 6 STATUS: bit0 PEND; writing 1 clears it, writing 0 has no effect
- 7 unmapped
REQ-017 gnt SHALL equal req combinationally; every request is accepted in the cycle it is presented.
REQ-018 Reads: rvalid SHALL pulse exactly one cycle after the accepted read, with rdata valid in that same cycle; rdata SHALL be 0 whenever rvalid is 0.
REQ-019 Writes SHALL update only the bytes whose be bit is set; writes produce no rvalid.
REQ-020 Unmapped address: reads SHALL return 0 with the normal rvalid; writes SHALL be ignored.
REQ-021 Prescaler: the divider counter counts up every cycle while EN=1.
- When the counter equals PRESCALE, it SHALL produce a one-cycle tick and return to 0.
- PRESCALE=0 SHALL give a tick every cycle.
- While EN=0 the counter SHALL hold at 0.
REQ-022 mtime (64-bit) SHALL increment by 1 on each tick and wrap from 2^64-1 to 0.
REQ-023 A write to MTIME_LO or MTIME_HI in the same cycle as a tick: the write wins and no increment occurs that cycle.
REQ-024 Atomic read of mtime: reading MTIME_LO SHALL latch mtime[63:32] into a shadow register; reading MTIME_HI SHALL return the shadow, not the live value.
REQ-025 Compare condition: match = EN & IE & (mtime >= mtimecmp), evaluated as a 64-bit unsigned comparison on current register values.
REQ-026 PEND SHALL be set on the cycle after match is true and stays set (sticky).
REQ-027 PEND SHALL be cleared by a complete pulse or by a write-1-to-clear to STATUS.
REQ-028 When a set and a clear of PEND occur in the same cycle, the set SHALL win.
REQ-029 pending SHALL equal PEND, driven directly from a register.
REQ-030 Changing mtimecmp SHALL NOT clear PEND; only REQ-027 clears it.

Reset
REQ-031 On rst=1, asynchronously, the block SHALL set:
- mtime=0, shadow=0
- mtimecmp=64'hFFFF_FFFF_FFFF_FFFF
- CTRL=0, PRESCALE=0, divider=0
- PEND=0, pending=0, rvalid=0, rdata=0
REQ-032 gnt is combinational and SHALL follow req during reset; writes accepted while rst=1 SHALL have no effect.
REQ-033 Reset asserted mid-transaction SHALL drop any outstanding rvalid; no rvalid SHALL appear after rst deasserts for a read issued before it.

Verification
REQ-034 Counting: PRESCALE=3, CTRL=1, then hold 40 cycles -> mtime=10 (±1 for the enable-cycle alignment), incrementing exactly every 4 cycles.
REQ-035 Wrap and atomic read: write mtime=64'h0000_0000_FFFF_FFFF with PRESCALE=0 and EN=1; read LO then HI across the carry -> the HI read returns 0 (the shadow value), and live mtime[63:32] becomes 1.
REQ-036 Interrupt: mtimecmp=5, CTRL=3, PRESCALE=0 from mtime=0 -> pending rises the cycle after mtime reaches 5.
- Pulse complete while mtime>=5 -> pending drops for at most 0 cycles (set wins).
- Then write CTRL=1 and pulse complete -> pending=0 and stays 0.
REQ-037 Byte enables: write MTIMECMP_LO=32'hAABBCCDD with be=4'b0101 from the reset value -> reads back 32'hFFBBFFDD.
REQ-038 Collision: a write of MTIME_LO=100 in a tick cycle -> next read returns 100, not 101; the STATUS W1C in the same cycle as match -> PEND=1.
REQ-039 Unmapped and reset: a read at addr 5'h1C -> rvalid next cycle with rdata=0; assert rst the cycle after a read request -> rvalid=0 and all registers at their REQ-031 values.

Source files
------------

// File: rtl/ladybird_timer.sv
// ladybird_timer: machine timer with prescaler, 64-bit mtime/mtimecmp, sticky pending and a simple req/gnt bus.
module ladybird_timer #(
  parameter int DIV_W = 8,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [4:0]       addr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [3:0]       be,
  output logic             gnt,
  output logic             rvalid,
  output logic [XLEN-1:0]  rdata,
  output logic             pending,
  input  logic             complete
);
  localparam logic [2:0] R_MLO = 3'd0, R_MHI = 3'd1, R_CLO = 3'd2, R_CHI = 3'd3,
                         R_CTRL = 3'd4, R_PRE = 3'd5, R_STAT = 3'd6;
  logic [63:0]      mtime, cmp;
  logic [31:0]      shadow, rd_val, wd;
  logic [DIV_W-1:0] pre, div;
  logic [2:0]       sel;
  logic             en, ie, pend, tick, match, wr, rd, clr;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i] ? d[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction
  assign gnt     = req;
  assign pending = pend;
  assign sel     = addr[4:2];
  assign wd      = wdata[31:0];
  assign wr      = req & we;
  assign rd      = req & ~we;
  assign tick    = en && (div == pre);
  assign match   = en && ie && (mtime >= cmp);
  assign clr     = complete | (wr && sel == R_STAT && be[0] && wd[0]);
  always_comb begin
    rd_val = sel == R_MLO  ? mtime[31:0] :
             sel == R_MHI  ? shadow :
             sel == R_CLO  ? cmp[31:0] :
             sel == R_CHI  ? cmp[63:32] :
             sel == R_CTRL ? {30'd0, ie, en} :
             sel == R_PRE  ? 32'(pre) :
             sel == R_STAT ? {31'd0, pend} : 32'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime  <= '0;
      shadow <= '0;
      cmp    <= '1;
      en     <= 1'b0;
      ie     <= 1'b0;
      pre    <= '0;
      div    <= '0;
      pend   <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      div    <= (tick || !en) ? '0 : div + 1'b1;
      pend   <= match | (pend & ~clr);
      rvalid <= rd;
      rdata  <= rd ? XLEN'(rd_val) : '0;
      if (rd && sel == R_MLO) shadow <= mtime[63:32];
      // a software write to either half suppresses that cycle's increment
      if (wr && sel == R_MLO) mtime[31:0] <= merge(mtime[31:0], wd, be);
      else if (wr && sel == R_MHI) mtime[63:32] <= merge(mtime[63:32], wd, be);
      else if (tick) mtime <= mtime + 64'd1;
      if (wr && sel == R_CLO) cmp[31:0] <= merge(cmp[31:0], wd, be);
      if (wr && sel == R_CHI) cmp[63:32] <= merge(cmp[63:32], wd, be);
      if (wr && sel == R_CTRL && be[0]) {ie, en} <= wd[1:0];
      if (wr && sel == R_PRE) pre <= DIV_W'(merge(32'(pre), wd, be));
    end
  end
endmodule

// File: tb/tb_ladybird_timer.sv
// tb_ladybird_timer: directed register-level checks of ladybird_timer with hand-computed expectations.
module tb_ladybird_timer;
  logic        clk = 0, rst = 1, req = 0, we = 0, complete = 0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0, rdata, d;
  logic [3:0]  be = '0;
  logic        gnt, rvalid, pending;
  int          n_chk = 0, n_err = 0;
  ladybird_timer #(.DIV_W(8), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .pending(pending), .complete(complete)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] v, input logic [3:0] b);
    req = 1; we = 1; addr = a; wdata = v; be = b;
    @(negedge clk);
    req = 0; we = 0;
    check("wr_no_rvalid", 32'(rvalid), 32'd0);
  endtask
  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    req = 1; we = 0; addr = a; be = '0;
    @(negedge clk);
    req = 0;
    check("rd_rvalid", 32'(rvalid), 32'd1);
    v = rdata;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic reset_values;
    rd(5'h00, d); check("rst_mtime_lo", d, 32'h0);
    rd(5'h04, d); check("rst_mtime_hi", d, 32'h0);
    rd(5'h08, d); check("rst_cmp_lo", d, 32'hFFFF_FFFF);
    rd(5'h0C, d); check("rst_cmp_hi", d, 32'hFFFF_FFFF);
    rd(5'h10, d); check("rst_ctrl", d, 32'h0);
    rd(5'h14, d); check("rst_prescale", d, 32'h0);
    rd(5'h18, d); check("rst_status", d, 32'h0);
    check("rst_pending", 32'(pending), 32'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    idle(2);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 0;
    idle(1);
    reset_values();
    req = 1; #1; check("gnt_follows_req", 32'(gnt), 32'd1); req = 0; #1;
    check("idle_rdata_zero", rdata, 32'd0);
    // byte-enable merge over the reset value of mtimecmp
    wr(5'h08, 32'hAABB_CCDD, 4'b0101);
    rd(5'h08, d); check("be_cmp_lo", d, 32'hFFBB_FFDD);
    // prescaler 3: first tick four edges after EN lands, then every four
    wr(5'h14, 32'd3, 4'hF);
    wr(5'h10, 32'd1, 4'hF);
    idle(40);
    rd(5'h00, d); check("count_40", d, 32'd10);
    idle(3);
    rd(5'h00, d); check("count_next_tick", d, 32'd11);
    // carry into the high word with an atomic LO/HI read pair
    wr(5'h10, 32'd0, 4'hF);
    wr(5'h14, 32'd0, 4'hF);
    wr(5'h00, 32'hFFFF_FFFF, 4'hF);
    wr(5'h04, 32'h0, 4'hF);
    wr(5'h10, 32'd1, 4'hF);
    rd(5'h00, d); check("wrap_lo", d, 32'hFFFF_FFFF);
    rd(5'h04, d); check("wrap_hi_shadow", d, 32'h0);
    rd(5'h00, d);
    rd(5'h04, d); check("wrap_hi_live", d, 32'h1);
    // interrupt: pending rises the cycle after mtime reaches 5
    wr(5'h10, 32'd0, 4'hF);
    wr(5'h00, 32'd0, 4'hF);
    wr(5'h04, 32'd0, 4'hF);
    wr(5'h0C, 32'd0, 4'hF);
    wr(5'h08, 32'd5, 4'hF);
    wr(5'h10, 32'd3, 4'hF);
    idle(5);
    check("irq_before", 32'(pending), 32'd0);
    idle(1);
    check("irq_rise", 32'(pending), 32'd1);
    complete = 1; idle(1); complete = 0;
    check("irq_set_wins", 32'(pending), 32'd1);
    wr(5'h10, 32'd1, 4'hF);
    complete = 1; idle(1); complete = 0;
    check("irq_cleared", 32'(pending), 32'd0);
    idle(5);
    check("irq_stays_clear", 32'(pending), 32'd0);
    rd(5'h18, d); check("status_clear", d, 32'h0);
    // write of mtime collides with a tick: write wins
    wr(5'h00, 32'd100, 4'hF);
    rd(5'h00, d); check("collide_mtime", d, 32'd100);
    wr(5'h10, 32'd3, 4'hF);
    wr(5'h18, 32'd1, 4'hF);
    check("w1c_vs_set", 32'(pending), 32'd1);
    wr(5'h10, 32'd1, 4'hF);
    wr(5'h18, 32'd1, 4'hF);
    check("w1c_clears", 32'(pending), 32'd0);
    rd(5'h1C, d); check("unmapped_rd", d, 32'h0);
    // reset lands while a read response is outstanding
    req = 1; we = 0; addr = 5'h00;
    @(negedge clk);
    req = 0;
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    rst = 1; #1;
    check("rst_drops_rvalid", 32'(rvalid), 32'd0);
    check("rst_drops_rdata", rdata, 32'd0);
    @(negedge clk);
    req = 1; we = 1; addr = 5'h10; wdata = 32'd3; be = 4'hF; #1;
    check("gnt_in_reset", 32'(gnt), 32'd1);
    @(negedge clk);
    req = 0; we = 0;
    rst = 0;
    idle(1);
    check("post_rst_rvalid", 32'(rvalid), 32'd0);
    reset_values();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
